// File: rtl/invaders_pkg.sv
// Shared constants for the invader renderer: screen and formation geometry,
// sprite bitmaps, row colours and the sprite lookup helper.
package invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int COLS     = 8;
  localparam int ROWS     = 4;
  localparam int CELL_W   = 32;
  localparam int CELL_H   = 16;
  localparam int ALIEN_W  = 16;
  localparam int ALIEN_H  = 8;
  localparam int X_START  = 64;
  localparam int Y_START  = 48;
  localparam int STEP     = 4;
  localparam int DROP     = 8;
  localparam int MOVE_DIV = 8;
  localparam int INVADE_Y = 400;
  localparam int PLAYER_Y = 440;
  localparam int PLAYER_W = 16;
  localparam int PLAYER_H = 8;

  localparam int N_ALIENS  = COLS * ROWS;
  localparam int CELL_W_SH = $clog2(CELL_W);
  localparam int CELL_H_SH = $clog2(CELL_H);
  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int CNT_W     = $clog2(MOVE_DIV);
  localparam int SPR_X_W   = $clog2(ALIEN_W);
  localparam int SPR_Y_W   = $clog2(ALIEN_H);

  // Bitmaps: entry [y] is one sprite line, bit 15 is the leftmost pixel.
  localparam logic [15:0] ALIEN_SPRITE [ALIEN_H] = '{
    16'b0000011111100000,
    16'b0001111111111000,
    16'b0011111111111100,
    16'b0111001111001110,
    16'b1111111111111111,
    16'b0011110000111100,
    16'b0110011001100110,
    16'b1100000000000011
  };

  localparam logic [15:0] PLAYER_SPRITE [PLAYER_H] = '{
    16'b0000000110000000,
    16'b0000001111000000,
    16'b0000001111000000,
    16'b0111111111111110,
    16'b1111111111111111,
    16'b1111111111111111,
    16'b1111111111111111,
    16'b1111111111111111
  };

  localparam logic [11:0] ROW_COLOUR [ROWS] = '{
    12'hF00, 12'hFF0, 12'h0FF, 12'hF0F
  };

  typedef enum logic [1:0] {
    MARCH_RIGHT,
    MARCH_LEFT,
    MARCH_FROZEN
  } march_state_e;

  // Everything stage 1 hands to stage 2 for one pixel.
  typedef struct packed {
    logic               disp;
    logic               in_form;
    logic               player;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [SPR_X_W-1:0] offx;
    logic [SPR_Y_W-1:0] offy;
    logic [SPR_X_W-1:0] poffx;
    logic [SPR_Y_W-1:0] poffy;
  } pix_s1_t;

  // Returns the bitmap pixel at in-sprite offset (x, y).
  function automatic logic sprite_bit(input logic               is_player,
                                      input logic [SPR_Y_W-1:0] y,
                                      input logic [SPR_X_W-1:0] x);
    logic [SPR_X_W-1:0] bit_pos;
    bit_pos = SPR_X_W'(ALIEN_W - 1) - x;
    return is_player ? PLAYER_SPRITE[y][bit_pos] : ALIEN_SPRITE[y][bit_pos];
  endfunction

endpackage

// File: rtl/formation_ctrl.sv
// Alien formation state: frame-end detect, march FSM, alive mask, kill port
// and the all_dead / landed status flags.
module formation_ctrl
  import invaders_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                v_display_i,
  input  logic                kill_valid_i,
  input  logic [1:0]          kill_row_i,
  input  logic [2:0]          kill_col_i,
  output logic [9:0]          form_x_o,
  output logic [8:0]          form_y_o,
  output logic [N_ALIENS-1:0] alive_o,
  output logic                all_dead_o,
  output logic                landed_o
);

  march_state_e        state_q, state_d;
  logic [9:0]          form_x_q, form_x_d;
  logic [8:0]          form_y_q, form_y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_ALIENS-1:0] alive_q, alive_d;
  logic                all_dead_q, all_dead_d;
  logic                landed_q, landed_d;
  logic                vdisp_q;
  logic                frame_end;

  // Falling edge of the vertical display flag marks one frame end.
  assign frame_end = vdisp_q & ~v_display_i;

  // State register for formation position, march direction and mask.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= MARCH_RIGHT;
      form_x_q   <= 10'(X_START);
      form_y_q   <= 9'(Y_START);
      cnt_q      <= '0;
      alive_q    <= '1;
      all_dead_q <= 1'b0;
      landed_q   <= 1'b0;
      vdisp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      form_x_q   <= form_x_d;
      form_y_q   <= form_y_d;
      cnt_q      <= cnt_d;
      alive_q    <= alive_d;
      all_dead_q <= all_dead_d;
      landed_q   <= landed_d;
      vdisp_q    <= v_display_i;
    end
  end

  // Next-state: kill, frame divider, march step, landing and freeze.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    form_x_d   = form_x_q;
    form_y_d   = form_y_q;
    cnt_d      = cnt_q;
    alive_d    = alive_q;
    landed_d   = landed_q;
    all_dead_d = ~|alive_q;

    // COLS is a power of two, so {row, col} is row*COLS+col and every
    // encodable index lands inside the mask.
    if (kill_valid_i) begin
      alive_d[{kill_row_i, kill_col_i}] = 1'b0;
    end

    if (frame_end && (state_q != MARCH_FROZEN) && !all_dead_q) begin
      if (cnt_q == CNT_W'(MOVE_DIV - 1)) begin
        cnt_d = '0;
        case (state_q)
          MARCH_RIGHT: begin
            if (({1'b0, form_x_q} + 11'(STEP)) > 11'(SCREEN_W - COLS * CELL_W)) begin
              form_y_d = form_y_q + 9'(DROP);
              state_d  = MARCH_LEFT;
            end else begin
              form_x_d = form_x_q + 10'(STEP);
            end
          end
          MARCH_LEFT: begin
            if (form_x_q < 10'(STEP)) begin
              form_y_d = form_y_q + 9'(DROP);
              state_d  = MARCH_RIGHT;
            end else begin
              form_x_d = form_x_q - 10'(STEP);
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Bottom of the formation reaching the landing line ends the march.
    if (({1'b0, form_y_d} + 10'(ROWS * CELL_H)) >= 10'(INVADE_Y)) begin
      landed_d = 1'b1;
      state_d  = MARCH_FROZEN;
    end

    if (all_dead_q) begin
      state_d = MARCH_FROZEN;
    end
  end

  assign form_x_o   = form_x_q;
  assign form_y_o   = form_y_q;
  assign alive_o    = alive_q;
  assign all_dead_o = all_dead_q;
  assign landed_o   = landed_q;

endmodule

// File: rtl/invader_renderer.sv
// Pixel-colour stage: two-clock pipeline from (haddr, vaddr) to registered
// 12-bit RGB, drawing the alien formation and the player ship.
module invader_renderer
  import invaders_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  haddr,
  input  logic [8:0]  vaddr,
  input  logic        h_display,
  input  logic        v_display,
  input  logic [9:0]  player_x,
  input  logic        kill_valid,
  input  logic [1:0]  kill_row,
  input  logic [2:0]  kill_col,
  output logic [11:0] rgb,
  output logic [9:0]  form_x,
  output logic [8:0]  form_y,
  output logic        all_dead,
  output logic        landed
);

  localparam int DXC_W = 10 - CELL_W_SH;
  localparam int DYR_W = 9 - CELL_H_SH;

  logic [N_ALIENS-1:0] alive;

  formation_ctrl u_formation (
    .clk          (clk),
    .rst          (rst),
    .v_display_i  (v_display),
    .kill_valid_i (kill_valid),
    .kill_row_i   (kill_row),
    .kill_col_i   (kill_col),
    .form_x_o     (form_x),
    .form_y_o     (form_y),
    .alive_o      (alive),
    .all_dead_o   (all_dead),
    .landed_o     (landed)
  );

  // Stage 1 geometry. The extra top bit of each difference is the borrow:
  // set means the pixel lies left of / above the reference point.
  logic [10:0]      dx, pdx;
  logic [9:0]       dy, pdy;
  logic [DXC_W-1:0] col_full;
  logic [DYR_W-1:0] row_full;
  logic             in_form;
  logic             player_hit;

  assign dx       = {1'b0, haddr} - {1'b0, form_x};
  assign dy       = {1'b0, vaddr} - {1'b0, form_y};
  assign pdx      = {1'b0, haddr} - {1'b0, player_x};
  assign pdy      = {1'b0, vaddr} - 10'(PLAYER_Y);
  assign col_full = dx[9:CELL_W_SH];
  assign row_full = dy[8:CELL_H_SH];

  assign in_form = ~dx[10] & ~dy[9]
                 & (col_full < DXC_W'(COLS))
                 & (row_full < DYR_W'(ROWS))
                 & (dx[CELL_W_SH-1:0] < CELL_W_SH'(ALIEN_W))
                 & (dy[CELL_H_SH-1:0] < CELL_H_SH'(ALIEN_H));

  assign player_hit = (pdx < 11'(PLAYER_W)) & (pdy < 10'(PLAYER_H));

  pix_s1_t     s1_d, s1_q;
  logic [11:0] rgb_d, rgb_q;
  logic        alien_px, player_px;

  // Pack the stage-1 results for registering.
  always_comb begin
    s1_d         = '0;
    s1_d.disp    = h_display & v_display;
    s1_d.in_form = in_form;
    s1_d.player  = player_hit;
    s1_d.row     = row_full[ROW_W-1:0];
    s1_d.col     = col_full[COL_W-1:0];
    s1_d.offx    = dx[SPR_X_W-1:0];
    s1_d.offy    = dy[SPR_Y_W-1:0];
    s1_d.poffx   = pdx[SPR_X_W-1:0];
    s1_d.poffy   = pdy[SPR_Y_W-1:0];
  end

  // Stage 2: sprite lookup and colour priority (blank, player, alien).
  assign alien_px  = s1_q.in_form & alive[{s1_q.row, s1_q.col}]
                   & sprite_bit(1'b0, s1_q.offy, s1_q.offx);
  assign player_px = s1_q.player & sprite_bit(1'b1, s1_q.poffy, s1_q.poffx);

  // Colour select for the registered output.
  always_comb begin
    rgb_d = 12'h000;
    if (!s1_q.disp) begin
      rgb_d = 12'h000;
    end else if (player_px) begin
      rgb_d = 12'h0F0;
    end else if (alien_px) begin
      rgb_d = ROW_COLOUR[s1_q.row];
    end
  end

  // Pipeline registers; reset flushes any pixel in flight.
  always_ff @(posedge clk) begin
    // NOTE: the pipeline is plain flops, not a memory, so clearing it on
    // reset is cheap and guarantees no stale pixel escapes after rst.
    if (rst) begin
      s1_q  <= '0;
      rgb_q <= '0;
    end else begin
      s1_q  <= s1_d;
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_invader_renderer.sv
// Self-checking bench for invader_renderer: directed and randomized pixels
// against an arithmetic reference model, march, kill, landing and reset.
module tb_invader_renderer;
  import invaders_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  haddr;
  logic [8:0]  vaddr;
  logic        h_display, v_display;
  logic [9:0]  player_x;
  logic        kill_valid;
  logic [1:0]  kill_row;
  logic [2:0]  kill_col;
  logic [11:0] rgb;
  logic [9:0]  form_x;
  logic [8:0]  form_y;
  logic        all_dead, landed;

  invader_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .haddr      (haddr),
    .vaddr      (vaddr),
    .h_display  (h_display),
    .v_display  (v_display),
    .player_x   (player_x),
    .kill_valid (kill_valid),
    .kill_row   (kill_row),
    .kill_col   (kill_col),
    .rgb        (rgb),
    .form_x     (form_x),
    .form_y     (form_y),
    .all_dead   (all_dead),
    .landed     (landed)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model of the formation.
  int        m_x, m_y, m_dir, m_cnt;
  bit        m_landed, m_stepped, m_dropped;
  bit [31:0] m_alive;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_x = 64; m_y = 48; m_dir = 1; m_cnt = 0;
    m_landed = 0; m_alive = 32'hFFFF_FFFF;
  endtask

  function automatic logic [11:0] model_rgb(int h, int v, bit hd, int px,
                                            int fx, int fy, bit [31:0] alv);
    int dx, dy, pdx, pdy, r, c;
    if (!hd) return 12'h000;
    pdx = h - px;
    pdy = v - 440;
    if (pdx >= 0 && pdx < 16 && pdy >= 0 && pdy < 8 && PLAYER_SPRITE[pdy][15 - pdx])
      return 12'h0F0;
    dx = h - fx;
    dy = v - fy;
    if (dx < 0 || dy < 0) return 12'h000;
    c = dx / 32;
    r = dy / 16;
    if (c >= 8 || r >= 4 || (dx % 32) >= 16 || (dy % 16) >= 8) return 12'h000;
    if (alv[r * 8 + c] && ALIEN_SPRITE[dy % 16][15 - (dx % 32)]) return ROW_COLOUR[r];
    return 12'h000;
  endfunction

  // Drive one pixel (v_display held high) and check rgb two clocks later.
  task automatic pix(input string tag, input int h, input int v, input bit hd, input int px);
    logic [11:0] exp;
    if (h < 0) h = 0;
    if (h > 639) h = 639;
    if (v < 0) v = 0;
    if (v > 479) v = 479;
    haddr = 10'(h); vaddr = 9'(v); h_display = hd; v_display = 1'b1; player_x = 10'(px);
    exp = model_rgb(h, v, hd, px, m_x, m_y, m_alive);
    tick();
    tick();
    check(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic kill(input int r, input int c);
    kill_valid = 1'b1; kill_row = 2'(r); kill_col = 3'(c);
    tick();
    kill_valid = 1'b0;
    m_alive[r * 8 + c] = 1'b0;
  endtask

  // One frame end (v_display falling), optionally with a kill in that cycle.
  task automatic frame(input bit with_kill, input int kr, input int kc);
    bit frozen;
    frozen = m_landed || (m_alive == 32'h0);
    h_display = 1'b0; v_display = 1'b0;
    if (with_kill) begin
      kill_valid = 1'b1; kill_row = 2'(kr); kill_col = 3'(kc);
    end
    tick();
    kill_valid = 1'b0; v_display = 1'b1;
    tick();
    if (with_kill) m_alive[kr * 8 + kc] = 1'b0;
    m_stepped = 0; m_dropped = 0;
    if (!frozen) begin
      if (m_cnt == 7) begin
        m_cnt = 0; m_stepped = 1;
        if (m_dir > 0) begin
          if (m_x + 4 > 640 - 256) begin m_y += 8; m_dir = -1; m_dropped = 1; end
          else m_x += 4;
        end else begin
          if (m_x < 4) begin m_y += 8; m_dir = 1; m_dropped = 1; end
          else m_x -= 4;
        end
        if (m_y + 64 >= 400) m_landed = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    int n, fy_land;
    bit seen_drop;
    bit after_drop;

    rst = 1'b1; haddr = '0; vaddr = '0; h_display = 1'b0; v_display = 1'b1;
    player_x = '0; kill_valid = 1'b0; kill_row = '0; kill_col = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_form_x", 32'(form_x), 32'd64);
    check("rst_form_y", 32'(form_y), 32'd48);
    check("rst_alive", dut.u_formation.alive_q, 32'hFFFF_FFFF);
    check("rst_all_dead", 32'(all_dead), 32'h0);
    check("rst_landed", 32'(landed), 32'h0);

    // Directed pixels: sprite bit, gap column, blanked line
    pix("alien_row0_k5", 64 + 5, 48, 1'b1, 300);
    check("alien_row0_colour", 32'(rgb), 32'(ROW_COLOUR[0]));
    pix("alien_gap", 80, 48, 1'b1, 300);
    pix("h_blank", 64 + 5, 48, 1'b0, 300);
    pix("left_of_form", 60, 50, 1'b1, 300);

    // Randomized formation and player pixels
    for (int i = 0; i < 24; i++)
      pix($sformatf("rand_alien%0d", i), m_x - 8 + int'($urandom_range(0, 280)),
          m_y - 8 + int'($urandom_range(0, 80)), $urandom_range(0, 4) != 0, 300);
    pix("player_k7", 300 + 7, 440, 1'b1, 300);
    for (int i = 0; i < 12; i++) begin
      int px;
      px = int'($urandom_range(0, 620));
      pix($sformatf("rand_player%0d", i), px - 4 + int'($urandom_range(0, 24)),
          436 + int'($urandom_range(0, 14)), 1'b1, px);
    end

    // March: no step before the 8th frame end; kill lands with that frame end
    for (int i = 0; i < 7; i++) frame(1'b0, 0, 0);
    check("pre_step_x", 32'(form_x), 32'd64);
    frame(1'b1, 0, 0);
    check("step_x_68", 32'(form_x), 32'd68);
    check("step_y_48", 32'(form_y), 32'd48);
    check("kill_with_frame", dut.u_formation.alive_q, m_alive);
    pix("killed_cell00", m_x + 5, m_y, 1'b1, 300);
    pix("live_cell01", m_x + 32 + 5, m_y, 1'b1, 300);

    // Kill (2,3): that cell goes black, neighbour stays lit; repeat is a no-op
    kill(2, 3);
    pix("killed_cell23", m_x + 96 + 5, m_y + 32, 1'b1, 300);
    pix("live_cell22", m_x + 64 + 5, m_y + 32, 1'b1, 300);
    check("live_cell22_colour", 32'(rgb), 32'(ROW_COLOUR[2]));
    kill(2, 3);
    check("repeat_kill", dut.u_formation.alive_q, m_alive);
    for (int i = 0; i < 10; i++)
      pix($sformatf("rand_after_kill%0d", i), m_x + int'($urandom_range(0, 256)),
          m_y + int'($urandom_range(0, 64)), 1'b1, 300);

    // Kill all: all_dead follows one cycle after the mask empties, then freezes
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        kill(r, c);
    check("alive_empty", dut.u_formation.alive_q, 32'h0);
    check("all_dead_lag", 32'(all_dead), 32'h0);
    tick();
    check("all_dead_set", 32'(all_dead), 32'h1);
    for (int i = 0; i < 16; i++) frame(1'b0, 0, 0);
    check("dead_frozen_x", 32'(form_x), 32'(m_x));
    check("dead_frozen_y", 32'(form_y), 32'(m_y));

    // Reset mid-frame with a lit player pixel in flight
    pix("player_before_rst", 307, 440, 1'b1, 300);
    check("player_colour", 32'(rgb), 32'h0F0);
    rst = 1'b1;
    tick();
    check("midrst_rgb", 32'(rgb), 32'h0);
    check("midrst_form_x", 32'(form_x), 32'd64);
    check("midrst_form_y", 32'(form_y), 32'd48);
    check("midrst_all_dead", 32'(all_dead), 32'h0);
    check("midrst_landed", 32'(landed), 32'h0);
    check("midrst_alive", dut.u_formation.alive_q, 32'hFFFF_FFFF);
    rst = 1'b0;
    model_reset();
    tick();
    check("flushed_pipe", 32'(rgb), 32'h0);
    tick();
    check("post_rst_player", 32'(rgb), 32'h0F0);

    // March until landing; check every step, the first edge drop, the turn
    n = 0; seen_drop = 0; after_drop = 0;
    while (!m_landed && n < 40000) begin
      frame(1'b0, 0, 0);
      n++;
      if (m_stepped) begin
        check("march_x", 32'(form_x), 32'(m_x));
        check("march_y", 32'(form_y), 32'(m_y));
        check("march_landed", 32'(landed), 32'(m_landed));
        if (after_drop) begin
          check("after_drop_x", 32'(form_x), 32'd380);
          after_drop = 0;
        end
        if (m_dropped && !seen_drop) begin
          seen_drop = 1; after_drop = 1;
          check("first_drop_x", 32'(form_x), 32'd384);
          check("first_drop_y", 32'(form_y), 32'd56);
        end
      end
    end
    check("land_y", 32'(form_y), 32'd336);
    check("land_flag", 32'(landed), 32'h1);
    fy_land = m_y;
    for (int i = 0; i < 16; i++) frame(1'b0, 0, 0);
    check("landed_frozen_x", 32'(form_x), 32'(m_x));
    check("landed_frozen_y", 32'(form_y), 32'(fy_land));
    check("landed_sticky", 32'(landed), 32'h1);
    pix("landed_pixel", m_x + 5, m_y, 1'b1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
